// File: rtl/stream_fifo.sv
// stream_fifo: single-clock FIFO with registered or first-word-fall-through read, level flags and sticky errors
module stream_fifo #(
  parameter int WBITS = 8,
  parameter int DEPTH = 4096,
  parameter int FWFT = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr,
  input  logic [WBITS-1:0] dataIn,
  input  logic             rd,
  output logic [WBITS-1:0] dataOut,
  output logic             dout_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow,
  output logic [CW-1:0]    cnt
);
  logic [WBITS-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WBITS-1:0] dout_q;
  logic dv_q, armed, rd_acc, wr_acc;
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  assign almost_empty = cnt <= CW'(AE_LEVEL);
  assign almost_full = cnt >= CW'(AF_LEVEL);
  // armed stays low for the first edge after reset release so a request racing the release is ignored
  assign rd_acc = armed & ~flush & rd & ~empty;
  assign wr_acc = armed & ~flush & wr & (~full | rd_acc);
  assign dataOut = (FWFT != 0 && !empty) ? mem[rd_ptr] : dout_q;
  assign dout_valid = (FWFT != 0) ? ~empty : dv_q;
  // storage array, never reset
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= dataIn;
  // pointers, occupancy, registered read port and sticky error flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      armed <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      dout_q <= '0;
      dv_q <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt <= '0;
        dv_q <= 1'b0;
        overflow <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
        if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt + CW'(wr_acc) - CW'(rd_acc);
        dv_q <= rd_acc;
        if (rd_acc && FWFT == 0) dout_q <= mem[rd_ptr];
        if (armed && wr && !wr_acc) overflow <= 1'b1;
        if (armed && rd && empty) underflow <= 1'b1;
      end
    end
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: scoreboard bench for stream_fifo in registered and first-word-fall-through modes
module tb_stream_fifo;
  logic clk = 0, rst = 1, flush = 0, wr = 0, rd = 0, wr1 = 0, rd1 = 0;
  logic [7:0] din = 0, din1 = 0, dout, dout1;
  logic dv, dv1, em, em1, fu, fu1, ae, ae1, af, af1, ov, ov1, uf, uf1;
  logic [3:0] cnt, cnt1;
  int errs = 0, checks = 0;
  logic [7:0] mq[$], exp_q[$];

  always #5 clk = ~clk;

  stream_fifo #(.WBITS(8), .DEPTH(8), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr(wr), .dataIn(din), .rd(rd),
    .dataOut(dout), .dout_valid(dv), .empty(em), .full(fu),
    .almost_empty(ae), .almost_full(af), .overflow(ov), .underflow(uf), .cnt(cnt)
  );

  stream_fifo #(.WBITS(8), .DEPTH(8), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .wr(wr1), .dataIn(din1), .rd(rd1),
    .dataOut(dout1), .dout_valid(dv1), .empty(em1), .full(fu1),
    .almost_empty(ae1), .almost_full(af1), .overflow(ov1), .underflow(uf1), .cnt(cnt1)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask

  // one clock of stimulus; the model decides acceptance and queues the word a read must return
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic f = 1'b0);
    bit rok, wok;
    rok = r && mq.size() > 0;
    wok = w && (mq.size() < 8 || rok);
    if (f) mq.delete();
    else begin
      if (rok) exp_q.push_back(mq.pop_front());
      if (wok) mq.push_back(d);
    end
    wr = w; rd = r; din = d; flush = f;
    @(posedge clk);
    #1;
    wr = 0; rd = 0; flush = 0;
  endtask

  // monitor: every valid word on the registered-read FIFO must match the scoreboard head
  always @(negedge clk)
    if (rst && dv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_valid: got dout_valid=1 data %0h, expected no valid word", dout);
      end else chk("read_data", dout, exp_q.pop_front());
    end

  initial begin
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", cnt, 0);
    chk("rst_empty", em, 1);
    chk("rst_aempty", ae, 1);
    chk("rst_full", fu, 0);
    chk("rst_afull", af, 0);
    chk("rst_dv", dv, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ov", ov, 0);
    chk("rst_uf", uf, 0);
    rst = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 8'(8'h11 + i));
      chk("fill_afull", af, (i + 1) >= 4);
      chk("fill_aempty", ae, (i + 1) <= 4);
    end
    chk("fill_full", fu, 1);
    chk("fill_cnt", cnt, 8);
    cyc(1, 0, 8'h99);
    chk("ovf_flag", ov, 1);
    chk("ovf_cnt", cnt, 8);
    cyc(1, 1, 8'h19);
    chk("full_rw_cnt", cnt, 8);
    chk("full_rw_full", fu, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);
    chk("drain_empty", em, 1);
    chk("drain_cnt", cnt, 0);
    chk("drain_dv", dv, 0);
    cyc(1, 1, 8'h55);
    chk("empty_rw_uf", uf, 1);
    chk("empty_rw_cnt", cnt, 1);
    chk("empty_rw_dv", dv, 0);
    cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00, 1'b1);
    chk("flush_uf", uf, 0);
    chk("flush_empty", em, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 8'(8'h30 + i));
      chk("pair_cnt_w", cnt, 1);
      cyc(0, 1, 8'h00);
      chk("pair_cnt_r", cnt, 0);
    end
    for (int i = 0; i < 9; i++) cyc(1, 0, 8'(8'h40 + i));
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h00);
    chk("pre_flush_cnt", cnt, 5);
    chk("pre_flush_ov", ov, 1);
    cyc(1, 0, 8'h50, 1'b1);
    chk("flush_wr_cnt", cnt, 0);
    chk("flush_wr_ov", ov, 0);
    chk("flush_wr_empty", em, 1);
    cyc(1, 0, 8'h61);
    cyc(1, 0, 8'h62);
    cyc(0, 1, 8'h00);
    wr = 1; din = 8'h63;
    rst = 0;
    exp_q.delete();
    mq.delete();
    #1;
    chk("async_cnt", cnt, 0);
    chk("async_empty", em, 1);
    chk("async_aempty", ae, 1);
    chk("async_full", fu, 0);
    chk("async_afull", af, 0);
    chk("async_dv", dv, 0);
    chk("async_dout", dout, 0);
    chk("async_ov", ov, 0);
    chk("async_uf", uf, 0);
    @(posedge clk);
    #1;
    rst = 1; din = 8'hEE;
    @(posedge clk);
    #1;
    wr = 0;
    chk("release_edge_ignored", cnt, 0);
    cyc(1, 0, 8'h77);
    cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);
    wr1 = 1; din1 = 8'hA5;
    @(posedge clk);
    #1;
    wr1 = 0;
    chk("fwft_dv", dv1, 1);
    chk("fwft_data", dout1, 8'hA5);
    chk("fwft_empty", em1, 0);
    rd1 = 1;
    @(posedge clk);
    #1;
    rd1 = 0;
    chk("fwft_pop_empty", em1, 1);
    chk("fwft_pop_dv", dv1, 0);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
